// File: rtl/vic_dram_seq.sv
// ---------------------------------------------------------------------------
// vic_dram_seq -- DRAM address sequencer for the VIC address path.
//
// A start pulse latches the access request. A timed state machine then drives
// the row/column-multiplexed DRAM address bus and the RAS/CAS strobes.
// Refresh accesses are RAS-only. Their row comes from the internal refresh row
// counter, which counts down by one after each refresh. Everything runs in the
// clk_dot4x domain.
//
// Sequence: S_IDLE -> S_ROW -> S_RAS (RAS_HOLD) -> [S_CAS (CAS_HOLD)] -> S_END
//
// Optional feature: define VIC_DRAM_REFC_LOAD_EN to add the refc_load and
// refc_val inputs. They load the refresh counter directly, and a load wins
// over a refresh decrement in the same cycle.
//
// Ports:
//   clk_dot4x  in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle access request, honoured only when idle
//   refresh    in   marks the requested access as a refresh
//   addr_in    in   [ADDR_W]        access address, captured on acceptance
//   refc_load  in   (macro only)    load refresh counter from refc_val
//   refc_val   in   (macro only)    [REFC_W] refresh counter load value
//   ado_mux    out  [ROW_W]         multiplexed row/column address pins
//   ado_hi     out  [ADDR_W-ROW_W]  non-multiplexed upper address bits
//   ras_n      out  row strobe, active-low
//   cas_n      out  column strobe, active-low
//   busy       out  sequencer is not idle
//   done       out  one-cycle completion pulse
//   overrun    out  sticky: a start arrived while busy
//   refc       out  [REFC_W]        refresh row counter
// ---------------------------------------------------------------------------
module vic_dram_seq #(
    parameter int ADDR_W   = 14,
    parameter int ROW_W    = 8,
    parameter int RAS_HOLD = 2,
    parameter int CAS_HOLD = 2,
    parameter int REFC_W   = 8
) (
    input  logic                    clk_dot4x,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    refresh,
    input  logic [ADDR_W-1:0]       addr_in,
`ifdef VIC_DRAM_REFC_LOAD_EN
    input  logic                    refc_load,
    input  logic [REFC_W-1:0]       refc_val,
`endif
    output logic [ROW_W-1:0]        ado_mux,
    output logic [ADDR_W-ROW_W-1:0] ado_hi,
    output logic                    ras_n,
    output logic                    cas_n,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [REFC_W-1:0]       refc
);

    localparam int HI_W = ADDR_W - ROW_W;

    // Upper pin bits that the row value does not cover are driven high.
    localparam logic [ROW_W-1:0] ADDR_PAD = {ROW_W{1'b1}} << HI_W;
    localparam logic [ROW_W-1:0] REFC_PAD = {ROW_W{1'b1}} << REFC_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_RAS  = 3'd2,
        S_CAS  = 3'd3,
        S_END  = 3'd4
    } state_t;

    // Row presented for a normal access: upper address bits, padded with ones.
    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
        return ROW_W'(a[ADDR_W-1:ROW_W]) | ADDR_PAD;
    endfunction

    // Row presented for a refresh: counter value, padded with ones.
    function automatic logic [ROW_W-1:0] refc_row(input logic [REFC_W-1:0] r);
        return ROW_W'(r) | REFC_PAD;
    endfunction

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic [ROW_W-1:0]    col_r, col_s;
    logic                refr_r, refr_s;
    logic [ROW_W-1:0]    mux_r, mux_s;
    logic [HI_W-1:0]     hi_r, hi_s;
    logic                ras_n_r, ras_n_s;
    logic                cas_n_r, cas_n_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                ovr_r, ovr_s;
    logic [REFC_W-1:0]   refc_r, refc_s;

    // Next-state, hold counter and output-register values.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        col_s   = col_r;
        refr_s  = refr_r;
        mux_s   = mux_r;
        hi_s    = hi_r;
        refc_s  = refc_r;

        // Strobes and done are registered from the current state, so they
        // trail the state by one cycle. The row therefore gets a full setup
        // cycle in S_ROW before RAS, and the column gets one before CAS.
        ras_n_s = !((state_r == S_RAS) || (state_r == S_CAS));
        cas_n_s = !(state_r == S_CAS);
        done_s  = (state_r == S_END);
        ovr_s   = ovr_r | (start & busy_r);

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    col_s   = addr_in[ROW_W-1:0];
                    refr_s  = refresh;
                    state_s = S_ROW;
                    if (refresh) begin
                        mux_s = refc_row(refc_r);
                        hi_s  = {HI_W{1'b1}};
                    end else begin
                        mux_s = addr_row(addr_in);
                        hi_s  = addr_in[ADDR_W-1:ROW_W];
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ROW: begin
                state_s = S_RAS;
                cnt_s   = 3'(RAS_HOLD - 1);
            end
            S_RAS: begin
                if (cnt_r == 3'd0) begin
                    if (refr_r) begin
                        state_s = S_END;
                    end else begin
                        state_s = S_CAS;
                        cnt_s   = 3'(CAS_HOLD - 1);
                        mux_s   = col_r;
                    end
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_CAS: begin
                if (cnt_r == 3'd0) begin
                    state_s = S_END;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_END: begin
                state_s = S_IDLE;
                if (refr_r) begin
                    refc_s = refc_r - REFC_W'(1'b1);
                end else begin
                    refc_s = refc_r;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

`ifdef VIC_DRAM_REFC_LOAD_EN
        // A direct load overrides any decrement in the same cycle.
        if (refc_load) begin
            refc_s = refc_val;
        end else begin
            refc_s = refc_s;
        end
`endif

        busy_s = (state_s != S_IDLE);
    end

    // State, hold counter, latched request and registered outputs.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
            col_r   <= {ROW_W{1'b0}};
            refr_r  <= 1'b0;
            mux_r   <= {ROW_W{1'b1}};
            hi_r    <= {HI_W{1'b1}};
            ras_n_r <= 1'b1;
            cas_n_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovr_r   <= 1'b0;
            refc_r  <= {REFC_W{1'b1}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            col_r   <= col_s;
            refr_r  <= refr_s;
            mux_r   <= mux_s;
            hi_r    <= hi_s;
            ras_n_r <= ras_n_s;
            cas_n_r <= cas_n_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ovr_r   <= ovr_s;
            refc_r  <= refc_s;
        end
    end

    assign ado_mux = mux_r;
    assign ado_hi  = hi_r;
    assign ras_n   = ras_n_r;
    assign cas_n   = cas_n_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = ovr_r;
    assign refc    = refc_r;

endmodule

// File: tb/tb_vic_dram_seq.sv
// ---------------------------------------------------------------------------
// tb_vic_dram_seq -- self-checking bench for vic_dram_seq (default params).
//
// A timeline model predicts every output on every cycle. For each accepted
// access it records the acceptance edge N and the done edge D. Each output is
// then a simple function of the current edge number relative to N and D.
// Directed sequences add hand-computed literal checks. When
// VIC_DRAM_REFC_LOAD_EN is defined, the counter-load feature is exercised too.
// ---------------------------------------------------------------------------
module tb_vic_dram_seq;

    localparam int ADDR_W = 14;
    localparam int ROW_W  = 8;
    localparam int RH     = 2;
    localparam int CH     = 2;
    localparam int REFC_W = 8;

    logic              clk_dot4x = 1'b0;
    logic              rst_n;
    logic              start;
    logic              refresh;
    logic [ADDR_W-1:0] addr_in;
    logic [ROW_W-1:0]  ado_mux;
    logic [5:0]        ado_hi;
    logic              ras_n, cas_n, busy, done, overrun;
    logic [REFC_W-1:0] refc;
`ifdef VIC_DRAM_REFC_LOAD_EN
    logic              refc_load = 1'b0;
    logic [REFC_W-1:0] refc_val  = 8'h00;
`endif

    always #5 clk_dot4x = ~clk_dot4x;

    vic_dram_seq #(
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .RAS_HOLD(RH), .CAS_HOLD(CH), .REFC_W(REFC_W)
    ) dut (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .start     (start),
        .refresh   (refresh),
        .addr_in   (addr_in),
`ifdef VIC_DRAM_REFC_LOAD_EN
        .refc_load (refc_load),
        .refc_val  (refc_val),
`endif
        .ado_mux   (ado_mux),
        .ado_hi    (ado_hi),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .refc      (refc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int         cyc = 0;
    bit         have_acc = 1'b0;
    int         acc_n, acc_d;
    bit         acc_ref;
    logic [7:0] acc_row, acc_col, m_refc = 8'hFF;
    logic [5:0] acc_hi;
    bit         m_ovr = 1'b0;
    bit         chk_en = 1'b0;

    // Advance the model at each active edge.
    always @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            have_acc = 1'b0;
            m_refc   = 8'hFF;
            m_ovr    = 1'b0;
        end else begin
            bit dec;
            cyc++;
            dec = have_acc && acc_ref && (cyc == acc_d);
            if (start === 1'b1) begin
                if (have_acc && cyc <= acc_d) begin
                    m_ovr = 1'b1;
                end else begin
                    have_acc = 1'b1;
                    acc_n    = cyc;
                    acc_ref  = refresh;
                    acc_d    = cyc + 2 + RH + (refresh ? 0 : CH);
                    acc_col  = addr_in[7:0];
                    acc_row  = refresh ? m_refc : {2'b11, addr_in[13:8]};
                    acc_hi   = refresh ? 6'h3F : addr_in[13:8];
                end
            end
            if (dec) m_refc = m_refc - 8'd1;
`ifdef VIC_DRAM_REFC_LOAD_EN
            if (refc_load === 1'b1) m_refc = refc_val;
`endif
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk_dot4x) begin
        if (rst_n && chk_en) begin
            logic [7:0] e_mux;
            logic       e_ras_n, e_cas_n, e_busy, e_done;
            e_busy  = have_acc && (cyc < acc_d);
            e_done  = have_acc && (cyc == acc_d);
            e_ras_n = !(have_acc && cyc >= acc_n + 2 && cyc < acc_d);
            e_cas_n = !(have_acc && !acc_ref && cyc >= acc_n + 2 + RH && cyc < acc_d);
            if (!have_acc)                               e_mux = 8'hFF;
            else if (!acc_ref && cyc >= acc_n + 1 + RH)  e_mux = acc_col;
            else                                         e_mux = acc_row;
            check("m_ado_mux", ado_mux, e_mux);
            check("m_ado_hi",  ado_hi,  have_acc ? acc_hi : 6'h3F);
            check("m_ras_n",   ras_n,   e_ras_n);
            check("m_cas_n",   cas_n,   e_cas_n);
            check("m_busy",    busy,    e_busy);
            check("m_done",    done,    e_done);
            check("m_overrun", overrun, m_ovr);
            check("m_refc",    refc,    m_refc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_dot4x);
        #1;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy === 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic r);
        addr_in = a;
        refresh = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Watchdog: any hang ends the run with a failure line.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; refresh = 1'b0; addr_in = 14'h0000;
        repeat (3) @(posedge clk_dot4x);
        #1;
        check("rst_ado_mux", ado_mux, 8'hFF);
        check("rst_ado_hi",  ado_hi,  6'h3F);
        check("rst_ras_n",   ras_n,   1'b1);
        check("rst_cas_n",   cas_n,   1'b1);
        check("rst_refc",    refc,    8'hFF);
        check("rst_busy",    busy,    1'b0);
        check("rst_done",    done,    1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Normal read of 0x2A55. Inputs change after acceptance and must be ignored.
        pulse_start(14'h2A55, 1'b0);                       // edge N
        addr_in = 14'h1234; refresh = 1'b1;
        check("rd_row_n",   ado_mux, 8'hEA);
        check("rd_hi",      ado_hi,  6'h2A);
        check("rd_busy",    busy,    1'b1);
        tick();                                            // N+1
        check("rd_row_n1",  ado_mux, 8'hEA);
        check("rd_ras_n1",  ras_n,   1'b1);
        tick();                                            // N+2
        check("rd_ras_n2",  ras_n,   1'b0);
        check("rd_cas_n2",  cas_n,   1'b1);
        tick();                                            // N+3
        check("rd_ras_n3",  ras_n,   1'b0);
        tick();                                            // N+4
        check("rd_col_n4",  ado_mux, 8'h55);
        check("rd_cas_n4",  cas_n,   1'b0);
        tick();                                            // N+5
        check("rd_cas_n5",  cas_n,   1'b0);
        check("rd_done_n5", done,    1'b0);
        tick();                                            // N+6
        check("rd_done_n6", done,    1'b1);
        check("rd_ras_n6",  ras_n,   1'b1);
        check("rd_hi_n6",   ado_hi,  6'h2A);
        tick();                                            // N+7
        check("rd_done_n7", done,    1'b0);

        // Three refreshes: rows FF, FE, FD, then the counter is at FC.
        for (int k = 0; k < 3; k++) begin
            pulse_start(14'h0000, 1'b1);
            check("ref_row", ado_mux, 8'hFF - 8'(k));
            wait_idle();
        end
        check("ref_refc_end", refc, 8'hFC);

        // Start during S_CAS: rejected, overrun set, access unaffected.
        pulse_start(14'h0F0F, 1'b0);                       // N
        tick(); tick(); tick();                            // N+3: in S_CAS
        addr_in = 14'h3FFF; start = 1'b1;
        tick();
        start = 1'b0;
        check("ovr_set", overrun, 1'b1);
        wait_idle();
        check("ovr_col",    ado_mux, 8'h0F);
        check("ovr_hi",     ado_hi,  6'h0F);
        check("ovr_sticky", overrun, 1'b1);

        // Back-to-back: a start held across S_END is accepted only once idle.
        pulse_start(14'h1122, 1'b0);                       // N
        repeat (5) tick();                                 // N+5: in S_END
        addr_in = 14'h0133; start = 1'b1;
        tick();                                            // D: rejected
        check("b2b_done", done, 1'b1);
        check("b2b_rej",  busy, 1'b0);
        tick();                                            // D+1: accepted
        start = 1'b0;
        check("b2b_acc",  busy,    1'b1);
        check("b2b_row",  ado_mux, 8'hC1);
        wait_idle();

        // Asynchronous reset in S_RAS: immediate abort, no done afterwards.
        pulse_start(14'h2000, 1'b0);
        tick(); tick();                                    // N+2
        check("ar_ras_low", ras_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ras_n",   ras_n,   1'b1);
        check("ar_busy",    busy,    1'b0);
        check("ar_overrun", overrun, 1'b0);
        check("ar_ado_mux", ado_mux, 8'hFF);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("ar_no_done", done, 1'b0);
        end

        // Wrap: step the counter from FF down to 00, then refresh twice more.
        for (int k = 0; k < 255; k++) begin
            pulse_start(14'h0000, 1'b1);
            wait_idle();
        end
        check("wrap_at_zero", refc, 8'h00);
        pulse_start(14'h0000, 1'b1);
        check("wrap_row00", ado_mux, 8'h00);
        check("wrap_cas",   cas_n,   1'b1);
        wait_idle();
        check("wrap_refc",  refc,    8'hFF);
        pulse_start(14'h0000, 1'b1);
        check("wrap_rowFF", ado_mux, 8'hFF);
        wait_idle();
        check("wrap_refc2", refc,    8'hFE);

`ifdef VIC_DRAM_REFC_LOAD_EN
        // Load coincides with the refresh S_END cycle: the load wins.
        pulse_start(14'h0000, 1'b1);                       // N
        tick(); tick(); tick();                            // N+3: in S_END
        refc_load = 1'b1; refc_val = 8'h10;
        tick();
        refc_load = 1'b0;
        check("ld_done", done, 1'b1);
        check("ld_refc", refc, 8'h10);
        tick();
        pulse_start(14'h0000, 1'b1);
        check("ld_row",  ado_mux, 8'h10);
        wait_idle();
        check("ld_refc_dec", refc, 8'h0F);
`endif

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
